// File: rtl/fir_pair_serializer.sv
// fir_pair_serializer
//   Back end of the two-parallel FIR path. Accepts one (even, odd) accumulator
//   pair per input handshake, queues pairs in a small FIFO, and re-serialises
//   them into one sample stream: even sample first, then odd. Each sample is
//   scaled from IN_W accumulator precision down to OUT_W.
//
//   Optional feature macro: ROUND_SAT_EN
//     undefined : out = in[SHIFT+OUT_W-1:SHIFT] (truncate, wraps), sat_cnt = 0
//     defined   : round half up, saturate to OUT_W, sat_cnt counts saturated
//                 samples (sticks at 16'hFFFF)
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   pair handshake; in_even/in_odd hold the pair (signed)
//     out_valid/out_ready sample handshake; out_data scaled sample (signed)
//     out_phase           0 = even sample, 1 = odd sample
//     sat_cnt             saturated-sample counter
module fir_pair_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_even,
  input  logic [IN_W-1:0]  in_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_phase,
  output logic [15:0]      sat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_e;

  // Each entry holds {odd, even}.
  logic [2*IN_W-1:0] fifo_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  phase_e           phase_q, phase_d;
  logic             out_valid_q, out_valid_d;
  logic             out_phase_q, out_phase_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             push, pop, load, avail;
  logic [2*IN_W-1:0] head;
  logic [IN_W-1:0]  sample;
  logic [OUT_W-1:0] scaled;
  logic             sat;

`ifdef ROUND_SAT_EN
  localparam logic [IN_W:0] RND_HALF = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [IN_W:0] SAT_MAX =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN =
    {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [IN_W:0]        rnd_sum;
  logic signed [IN_W:0] rnd_shift;
  logic [15:0]          sat_cnt_q, sat_cnt_d;

  // One extra bit of headroom so adding the half-LSB can never overflow.
  always_comb begin
    rnd_sum   = {sample[IN_W-1], sample} + RND_HALF;
    rnd_shift = $signed(rnd_sum) >>> SHIFT;
    sat       = 1'b0;
    scaled    = rnd_shift[OUT_W-1:0];
    if (rnd_shift > SAT_MAX) begin
      scaled = {1'b0, {(OUT_W-1){1'b1}}};
      sat    = 1'b1;
    end else if (rnd_shift < SAT_MIN) begin
      scaled = {1'b1, {(OUT_W-1){1'b0}}};
      sat    = 1'b1;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (load && sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  always_comb begin
    scaled = sample[SHIFT+OUT_W-1:SHIFT];
    sat    = 1'b0;
  end

  assign sat_cnt = 16'd0;
`endif

  always_comb begin
    push   = in_valid && in_ready_q;
    avail  = (count_q != '0);
    head   = fifo_mem[rd_ptr_q];
    sample = (phase_q == PH_ODD) ? head[2*IN_W-1:IN_W] : head[IN_W-1:0];
    // The output register refills whenever it is empty or being drained.
    load   = (!out_valid_q || out_ready) && avail;
    // A pair leaves the FIFO only once its odd half has been taken.
    pop    = load && (phase_q == PH_ODD);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Registered so a same-cycle pop never reopens a full FIFO.
    in_ready_d = (count_d != CW'(DEPTH));

    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_phase_d = out_phase_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = scaled;
      out_phase_d = phase_q;
      phase_d     = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_odd, in_even};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      phase_q     <= PH_EVEN;
      out_valid_q <= 1'b0;
      out_phase_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ROUND_SAT_EN
      sat_cnt_q   <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      out_data_q  <= out_data_d;
`ifdef ROUND_SAT_EN
      sat_cnt_q   <= sat_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_phase = out_phase_q;

endmodule
